mole_spawner: RTL
=================

// Module: mole_spawner
// PURPOSE
//  Upstream stage of the hit-matching logic: decides which of the 5 holes show a mole.
//  Pseudo-randomly spawns moles on a fixed interval, ages each one, and retires it on timeout (escape) or hit.
//  Drives molesGenerated[4:0] straight into the matcher and consumes the matcher's registered moleHit[2:0].
// PARAMETERS
//  SPAWN_INTERVAL  32'd25_000_000  cycles between spawn attempts (>=2)
//  MOLE_LIFETIME   32'd50_000_000  cycles a mole stays up if not hit (>=2)
//  MAX_ACTIVE      3               max simultaneous moles (1..5)
//  LFSR_SEED       16'hACE1        reset value of the 16-bit LFSR (must be nonzero)
//  SPEEDUP_STEP    32'd1_000_000   interval reduction per step (SPEEDUP_EN only)
//  MIN_INTERVAL    32'd5_000_000   interval floor (SPEEDUP_EN only)
// PORTS
//  clock           in   1   system clock, all state on posedge
//  resetn          in   1   asynchronous, active-low reset
//  enable          in   1   game running; low = hold IDLE, all holes empty
//  moleHit         in   3   from matcher: 0 none, 1..5 = hole 1..5 hit; 6,7 ignored
//  molesGenerated  out  5   bit i = mole up in hole i+1
//  moleEscaped     out  1   1-cycle pulse: >=1 mole timed out this cycle
//  spawnCount      out  8   spawns since leaving IDLE, saturates at 255
// BEHAVIOUR
//  Reset: molesGenerated=0, moleEscaped=0, spawnCount=0, state=IDLE, LFSR=LFSR_SEED, all counters 0.
//  LFSR: Fibonacci, taps 16,14,13,11; shifts every cycle enable=1, holds otherwise.
//  FSM IDLE -> WAIT when enable=1 (interval counter loaded with SPAWN_INTERVAL-1).
//   WAIT: decrement; at 0 -> SPAWN.  SPAWN: one cycle, then WAIT with counter reloaded.
//   Any state, enable=0 -> IDLE next cycle; clears molesGenerated, lifetimes, spawnCount; no escape pulse.
//  First spawn attempt: SPAWN_INTERVAL+1 cycles after enable rises (1 IDLE->WAIT + interval).
//  Candidate hole c = lfsr[2:0], values 5,6,7 fold to 0,1,2.
//  SPAWN: if popcount(molesGenerated) >= MAX_ACTIVE -> no spawn; else take first free hole
//   scanning c, c+1, ... wrapping 4->0 (single-cycle combinational search).
//  Occupancy for the search is the register value at the start of the cycle; a hole cleared that same cycle is not eligible.
//  Spawn: bit set next edge, lifetime[i] loaded MOLE_LIFETIME-1, spawnCount+1 (sat 255).
//  Lifetime: each up mole's counter decrements per cycle; at 0 bit clears next edge, moleEscaped=1 that cycle.
//  Visible duration = exactly MOLE_LIFETIME cycles if not hit.
//  Hit: moleHit=n (1..5) with bit n-1 set -> bit clears next edge, counter zeroed, no escape.
//  Hit on an empty hole: ignored (matcher reports the miss).
//  Hit and expiry on same hole same cycle: hit wins, moleEscaped stays 0 for that hole.
//  Multiple expiries same cycle: single moleEscaped pulse.
//  Async reset mid-spawn or mid-lifetime: all outputs to reset values immediately; no partial updates.
// CONFIGURATION
//  SPEEDUP_EN defined: every 8th successful spawn (spawnCount[2:0] wraps to 0) reduces the
//   active interval by SPEEDUP_STEP, floored at MIN_INTERVAL; active interval resets to SPAWN_INTERVAL in IDLE/reset.
//  SPEEDUP_EN undefined: interval fixed at SPAWN_INTERVAL; speedup register and logic absent.
// TESTING (bench params SPAWN_INTERVAL=4, MOLE_LIFETIME=10, MAX_ACTIVE=3, LFSR_SEED=16'hACE1)
//  1 enable rises at cycle 0 -> first spawn bit visible after edge 5; spawnCount=1; hole matches LFSR model.
//  2 No hits, 20 cycles -> never >3 bits set; each mole up exactly 10 cycles; moleEscaped pulses 1 cycle per expiry.
//  3 moleHit=idx of an up mole -> bit clears next edge, no escape; moleHit=7 or empty hole -> no change.
//  4 Force holes 1-2 up + candidate 2 (MAX_ACTIVE=5) -> spawn lands in hole 3; all 5 up -> no spawn, count unchanged.
//  5 Hit and expiry same cycle same hole -> bit cleared, moleEscaped=0; resetn low mid-WAIT -> all outputs 0 at once.
//  6 SPEEDUP_EN, STEP=1, MIN=2 -> after 8 spawns gap 4->3, after 16 ->2, stays 2; enable low restores 4.

Source files
------------

// File: rtl/mole_spawner.sv
// Mole spawner: drops pseudo-random moles into 5 holes, ages them and retires each on hit or escape.
// Optional define SPEEDUP_EN shortens the spawn interval after every 8th successful spawn.
module mole_spawner #(
  parameter int unsigned SPAWN_INTERVAL = 32'd25_000_000,
  parameter int unsigned MOLE_LIFETIME  = 32'd50_000_000,
  parameter int unsigned MAX_ACTIVE     = 3,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
`ifdef SPEEDUP_EN
  ,
  parameter int unsigned SPEEDUP_STEP   = 32'd1_000_000,
  parameter int unsigned MIN_INTERVAL   = 32'd5_000_000
`endif
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       enable,
  input  logic [2:0] moleHit,
  output logic [4:0] molesGenerated,
  output logic       moleEscaped,
  output logic [7:0] spawnCount
);

  typedef enum logic [1:0] {StIdle, StWait, StSpawn} state_e;

  state_e      r_state, w_state_next;
  logic [31:0] r_wait_cnt, w_wait_next;
  logic [31:0] r_life [5];
  logic [31:0] w_life_next [5];
  logic [4:0]  r_moles, w_moles_next;
  logic [7:0]  r_count, w_count_next;
  logic [15:0] r_lfsr, w_lfsr_next;
  logic [31:0] w_interval_next;

  logic [2:0]  w_cand;
  logic [2:0]  w_popcnt;
  logic        w_found;
  logic [2:0]  w_spawn_idx;
  logic [4:0]  w_hit_dec, w_hit_vec, w_expire;
  logic        w_spawn_ok;

  function automatic logic [2:0] wrap5(input logic [2:0] base, input int unsigned off);
    logic [3:0] s;
    s = {1'b0, base} + 4'(off);
    return (s >= 4'd5) ? 3'(s - 4'd5) : s[2:0];
  endfunction

  assign w_lfsr_next = enable ? {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]}
                              : r_lfsr;
  assign w_cand      = (r_lfsr[2:0] >= 3'd5) ? r_lfsr[2:0] - 3'd5 : r_lfsr[2:0];

  always_comb begin
    w_popcnt = '0;
    for (int i = 0; i < 5; i++) begin
      w_popcnt = w_popcnt + 3'(r_moles[i]);
    end
  end

  // First free hole from the candidate, wrapping; uses start-of-cycle occupancy only.
  always_comb begin
    w_found     = 1'b0;
    w_spawn_idx = '0;
    for (int k = 0; k < 5; k++) begin
      if (!w_found && !r_moles[wrap5(w_cand, k)]) begin
        w_found     = 1'b1;
        w_spawn_idx = wrap5(w_cand, k);
      end
    end
  end

  always_comb begin
    w_hit_dec = '0;
    case (moleHit)
      3'd1:    w_hit_dec[0] = 1'b1;
      3'd2:    w_hit_dec[1] = 1'b1;
      3'd3:    w_hit_dec[2] = 1'b1;
      3'd4:    w_hit_dec[3] = 1'b1;
      3'd5:    w_hit_dec[4] = 1'b1;
      default: w_hit_dec = '0;
    endcase
  end

  always_comb begin
    for (int i = 0; i < 5; i++) begin
      w_expire[i] = r_moles[i] && (r_life[i] == 32'd0);
    end
  end

  assign w_hit_vec   = w_hit_dec & r_moles;
  assign w_spawn_ok  = enable && (r_state == StSpawn) && (32'(w_popcnt) < MAX_ACTIVE) && w_found;
  assign moleEscaped = enable && |(w_expire & ~w_hit_vec);

`ifdef SPEEDUP_EN
  logic [31:0] r_interval;

  always_comb begin
    w_interval_next = r_interval;
    if (!enable) begin
      w_interval_next = 32'(SPAWN_INTERVAL);
    end else if (w_spawn_ok && (r_count != 8'hFF) && (r_count[2:0] == 3'd7)) begin
      w_interval_next = (r_interval >= 32'(MIN_INTERVAL) + 32'(SPEEDUP_STEP))
                      ? r_interval - 32'(SPEEDUP_STEP) : 32'(MIN_INTERVAL);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_interval <= 32'(SPAWN_INTERVAL);
    end else begin
      r_interval <= w_interval_next;
    end
  end
`else
  assign w_interval_next = 32'(SPAWN_INTERVAL);
`endif

  always_comb begin
    w_state_next = r_state;
    w_wait_next  = r_wait_cnt;
    case (r_state)
      StIdle: begin
        if (enable) begin
          w_state_next = StWait;
          w_wait_next  = w_interval_next - 32'd1;
        end
      end
      StWait: begin
        // Reaching 1 here means the interval elapses with the following SPAWN cycle.
        if (r_wait_cnt <= 32'd1) begin
          w_state_next = StSpawn;
          w_wait_next  = '0;
        end else begin
          w_wait_next  = r_wait_cnt - 32'd1;
        end
      end
      StSpawn: begin
        w_state_next = StWait;
        w_wait_next  = w_interval_next - 32'd1;
      end
      default: begin
        w_state_next = StIdle;
        w_wait_next  = '0;
      end
    endcase
    if (!enable) begin
      w_state_next = StIdle;
      w_wait_next  = '0;
    end
  end

  always_comb begin
    w_moles_next = r_moles;
    w_life_next  = r_life;
    w_count_next = r_count;
    if (!enable) begin
      w_moles_next = '0;
      w_count_next = '0;
      for (int i = 0; i < 5; i++) begin
        w_life_next[i] = '0;
      end
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (w_hit_vec[i]) begin
          w_moles_next[i] = 1'b0;
          w_life_next[i]  = '0;
        end else if (r_moles[i]) begin
          if (r_life[i] == 32'd0) begin
            w_moles_next[i] = 1'b0;
          end else begin
            w_life_next[i]  = r_life[i] - 32'd1;
          end
        end
      end
      if (w_spawn_ok) begin
        w_moles_next[w_spawn_idx] = 1'b1;
        w_life_next[w_spawn_idx]  = 32'(MOLE_LIFETIME) - 32'd1;
        if (r_count != 8'hFF) begin
          w_count_next = r_count + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state    <= StIdle;
      r_wait_cnt <= '0;
      r_moles    <= '0;
      r_count    <= '0;
      r_lfsr     <= LFSR_SEED;
      for (int i = 0; i < 5; i++) begin
        r_life[i] <= '0;
      end
    end else begin
      r_state    <= w_state_next;
      r_wait_cnt <= w_wait_next;
      r_moles    <= w_moles_next;
      r_count    <= w_count_next;
      r_lfsr     <= w_lfsr_next;
      for (int i = 0; i < 5; i++) begin
        r_life[i] <= w_life_next[i];
      end
    end
  end

  assign molesGenerated = r_moles;
  assign spawnCount     = r_count;

endmodule
